// File: rtl/stream_frame_framer.sv
// -----------------------------------------------------------------------------
// stream_frame_framer
//
// Pixel-stream front end for stream_neural_net. Turns a VSYNC/HSYNC framed
// raw pixel stream into a validated stream with a flat pixel index and
// start/end-of-frame flags. It also checks the frame geometry against
// WIDTH x HEIGHT and reports an error summary when each frame completes.
//
// Ports:
//   clk           - clock, all logic on the rising edge
//   rst_n         - synchronous reset, active low
//   VSYNC         - high for the duration of a frame
//   HSYNC         - high while the active pixels of a line are presented
//   in            - pixel, sampled when HSYNC=1 inside a frame
//   pix_out       - registered accepted pixel
//   pix_valid     - pix_out / pix_idx valid this cycle
//   pix_idx       - row*WIDTH+col of pix_out
//   sof / eof     - qualify pix_valid for index 0 / index WIDTH*HEIGHT-1
//   frame_done    - one-cycle pulse once VSYNC has fallen on an active frame
//   frame_err     - OR of err_code, valid with frame_done, held until the next
//   err_code      - [0] long line, [1] short line, [2] extra lines,
//                   [3] missing lines; valid with frame_done, held until next
//   frame_cnt     - (FRAMER_STATS_EN only) completed frames, wraps at 2^16
//   err_frame_cnt - (FRAMER_STATS_EN only) completed frames with an error
//
// Optional feature macro: FRAMER_STATS_EN adds the two statistics counters.
// -----------------------------------------------------------------------------
module stream_frame_framer #(
  parameter int  DATA_W = 16,
  parameter int  WIDTH  = 28,
  parameter int  HEIGHT = 28,
  localparam int IDX_W  = $clog2(WIDTH * HEIGHT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              VSYNC,
  input  logic              HSYNC,
  input  logic [DATA_W-1:0] in,
  output logic [DATA_W-1:0] pix_out,
  output logic              pix_valid,
  output logic [IDX_W-1:0]  pix_idx,
  output logic              sof,
  output logic              eof,
  output logic              frame_done,
  output logic              frame_err,
  output logic [3:0]        err_code
`ifdef FRAMER_STATS_EN
  ,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       err_frame_cnt
`endif
);

  // Row/col counters must be able to hold HEIGHT/WIDTH themselves, which mark
  // "frame full" and "line full". The running index counter must hold
  // WIDTH*HEIGHT because the line base is advanced past the last line.
  localparam int ROW_W = $clog2(HEIGHT + 1);
  localparam int COL_W = $clog2(WIDTH + 1);
  localparam int CNT_W = $clog2(WIDTH * HEIGHT + 1);

  localparam logic [ROW_W-1:0] ROW_MAX  = ROW_W'(HEIGHT);
  localparam logic [COL_W-1:0] COL_MAX  = COL_W'(WIDTH);
  localparam logic [CNT_W-1:0] LINE_INC = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH * HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic              vsync_q, vsync_d;
  logic              hsync_q, hsync_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [3:0]        err_q, err_d;
  logic [CNT_W-1:0]  base_q, base_d;
  logic [CNT_W-1:0]  idx_q, idx_d;

  logic [DATA_W-1:0] pix_out_q, pix_out_d;
  logic              pix_valid_q, pix_valid_d;
  logic [IDX_W-1:0]  pix_idx_q, pix_idx_d;
  logic              sof_q, sof_d;
  logic              eof_q, eof_d;
  logic              frame_done_q, frame_done_d;
  logic              frame_err_q, frame_err_d;
  logic [3:0]        err_code_q, err_code_d;
  logic [3:0]        err_final;
  logic              line_end;
`ifdef FRAMER_STATS_EN
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic [15:0]       err_frame_cnt_q, err_frame_cnt_d;
`endif

  always_comb begin
    state_d      = state_q;
    vsync_d      = VSYNC;
    hsync_d      = HSYNC;
    row_d        = row_q;
    col_d        = col_q;
    err_d        = err_q;
    base_d       = base_q;
    idx_d        = idx_q;
    pix_out_d    = pix_out_q;
    pix_valid_d  = 1'b0;
    pix_idx_d    = pix_idx_q;
    sof_d        = 1'b0;
    eof_d        = 1'b0;
    frame_done_d = 1'b0;
    frame_err_d  = frame_err_q;
    err_code_d   = err_code_q;
    err_final    = err_q;
    // A line ends when HSYNC drops, or when VSYNC drops while a line is open.
    line_end     = hsync_q && !(HSYNC && VSYNC);

    unique case (state_q)
      IDLE: begin
        // Only a real rising edge of VSYNC starts a frame.
        if (VSYNC && !vsync_q) begin
          state_d = ACTIVE;
          row_d   = '0;
          col_d   = '0;
          err_d   = '0;
          base_d  = '0;
          idx_d   = '0;
        end
      end

      ACTIVE: begin
        if (line_end) begin
          // Lines beyond HEIGHT are already flagged as extra, so they are not
          // also reported as short.
          if (row_q < ROW_MAX) begin
            if (col_q < COL_MAX) begin
              err_d[1] = 1'b1;
            end
            row_d  = row_q + ROW_W'(1);
            base_d = base_q + LINE_INC;
            idx_d  = base_q + LINE_INC;
          end
          col_d = '0;
        end else if (VSYNC && HSYNC) begin
          if (row_q == ROW_MAX) begin
            err_d[2] = 1'b1;
          end else if (col_q == COL_MAX) begin
            err_d[0] = 1'b1;
          end else begin
            pix_out_d   = in;
            pix_valid_d = 1'b1;
            pix_idx_d   = idx_q[IDX_W-1:0];
            sof_d       = (idx_q == '0);
            eof_d       = (idx_q == LAST_IDX);
            col_d       = col_q + COL_W'(1);
            idx_d       = idx_q + CNT_W'(1);
          end
        end

        // The report is registered on the way into DONE so that frame_done is
        // high exactly during the DONE cycle, with the missing-lines check
        // applied to the row count after any final line end.
        if (!VSYNC) begin
          state_d      = DONE;
          err_final    = err_d | {(row_d < ROW_MAX), 3'b000};
          err_d        = err_final;
          frame_done_d = 1'b1;
          err_code_d   = err_final;
          frame_err_d  = |err_final;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef FRAMER_STATS_EN
  always_comb begin
    frame_cnt_d     = frame_cnt_q + 16'(frame_done_d);
    err_frame_cnt_d = err_frame_cnt_q + 16'(frame_done_d & frame_err_d);
  end
`endif

  // VSYNC_q resets high so a VSYNC already asserted at reset release is not
  // mistaken for a frame start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      vsync_q      <= 1'b1;
      hsync_q      <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
      err_q        <= '0;
      base_q       <= '0;
      idx_q        <= '0;
      pix_out_q    <= '0;
      pix_valid_q  <= 1'b0;
      pix_idx_q    <= '0;
      sof_q        <= 1'b0;
      eof_q        <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      err_code_q   <= '0;
`ifdef FRAMER_STATS_EN
      frame_cnt_q     <= '0;
      err_frame_cnt_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      vsync_q      <= vsync_d;
      hsync_q      <= hsync_d;
      row_q        <= row_d;
      col_q        <= col_d;
      err_q        <= err_d;
      base_q       <= base_d;
      idx_q        <= idx_d;
      pix_out_q    <= pix_out_d;
      pix_valid_q  <= pix_valid_d;
      pix_idx_q    <= pix_idx_d;
      sof_q        <= sof_d;
      eof_q        <= eof_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      err_code_q   <= err_code_d;
`ifdef FRAMER_STATS_EN
      frame_cnt_q     <= frame_cnt_d;
      err_frame_cnt_q <= err_frame_cnt_d;
`endif
    end
  end

  assign pix_out    = pix_out_q;
  assign pix_valid  = pix_valid_q;
  assign pix_idx    = pix_idx_q;
  assign sof        = sof_q;
  assign eof        = eof_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign err_code   = err_code_q;
`ifdef FRAMER_STATS_EN
  assign frame_cnt     = frame_cnt_q;
  assign err_frame_cnt = err_frame_cnt_q;
`endif

endmodule
